// File: rtl/display_timing_gen.sv
// Purpose : raster timing generator for the ILI9341 RGB interface; walks nested
//           H/V sync -> back porch -> active -> front porch state machines and
//           produces the pixel coordinates and panel strobes.
// Latency : zero added latency. Every output is registered from the next-state
//           values, so it reflects the current dot on the edge the dot begins.
// Backpressure: none. The raster runs freely and loops with no gap between frames.
//
// Ports:
//   clk               system clock; one dot lasts CLKS_PER_PIXEL clocks
//   reset             asynchronous, active-high; returns the raster to dot (0,0)
//   display_x/y       active column/row, 0 outside the active region
//   in_display_region high while both machines are in their ACTIVE state
//   de                panel data enable, same value as in_display_region
//   hsync_n/vsync_n   panel syncs, active low
//   frame_start       one-clock pulse in the first dot of every frame
//   frame_count       16-bit wrapping frame counter, present only when
//                     DISPLAY_TIMING_FRAME_COUNT_EN is defined
//
// Optional feature macro: DISPLAY_TIMING_FRAME_COUNT_EN

module display_timing_gen #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int H_SYNC         = 10,
    parameter int H_BACK         = 20,
    parameter int H_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 2,
    parameter int V_FRONT        = 4,
    parameter int CLKS_PER_PIXEL = 4,
    parameter int WIDTH_BITS     = $clog2(DISPLAY_WIDTH),
    parameter int HEIGHT_BITS    = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  display_x,
    output logic [HEIGHT_BITS-1:0] display_y,
    output logic                   in_display_region,
    output logic                   de,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   frame_start
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]            frame_count
`endif
);

    // ------------------------------------------------------------------
    // Counter sizing: each counter must hold the longest state length - 1.
    // ------------------------------------------------------------------
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int H_MAX       = max4(H_SYNC, H_BACK, DISPLAY_WIDTH, H_FRONT);
    localparam int V_MAX       = max4(V_SYNC, V_BACK, DISPLAY_HEIGHT, V_FRONT);
    localparam int H_CNT_BITS  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam int V_CNT_BITS  = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam int PHASE_BITS  = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

    localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(CLKS_PER_PIXEL - 1);

    localparam logic [H_CNT_BITS-1:0] H_SYNC_LAST   = H_CNT_BITS'(H_SYNC - 1);
    localparam logic [H_CNT_BITS-1:0] H_BACK_LAST   = H_CNT_BITS'(H_BACK - 1);
    localparam logic [H_CNT_BITS-1:0] H_ACTIVE_LAST = H_CNT_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [H_CNT_BITS-1:0] H_FRONT_LAST  = H_CNT_BITS'(H_FRONT - 1);

    localparam logic [V_CNT_BITS-1:0] V_SYNC_LAST   = V_CNT_BITS'(V_SYNC - 1);
    localparam logic [V_CNT_BITS-1:0] V_BACK_LAST   = V_CNT_BITS'(V_BACK - 1);
    localparam logic [V_CNT_BITS-1:0] V_ACTIVE_LAST = V_CNT_BITS'(DISPLAY_HEIGHT - 1);
    localparam logic [V_CNT_BITS-1:0] V_FRONT_LAST  = V_CNT_BITS'(V_FRONT - 1);

    typedef enum logic [1:0] {
        H_SYNC_S   = 2'd0,
        H_BACK_S   = 2'd1,
        H_ACTIVE_S = 2'd2,
        H_FRONT_S  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_SYNC_S   = 2'd0,
        V_BACK_S   = 2'd1,
        V_ACTIVE_S = 2'd2,
        V_FRONT_S  = 2'd3
    } v_state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [PHASE_BITS-1:0]  r_phase;
    h_state_t               r_h_state;
    v_state_t               r_v_state;
    logic [H_CNT_BITS-1:0]  r_h_cnt;
    logic [V_CNT_BITS-1:0]  r_v_cnt;

    logic [WIDTH_BITS-1:0]  r_display_x;
    logic [HEIGHT_BITS-1:0] r_display_y;
    logic                   r_de;
    logic                   r_hsync_n;
    logic                   r_vsync_n;
    logic                   r_frame_start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic                   w_dot_end;
    logic                   w_h_last;
    logic                   w_v_last;
    logic [PHASE_BITS-1:0]  w_phase_nxt;
    h_state_t               w_h_state_nxt;
    v_state_t               w_v_state_nxt;
    logic [H_CNT_BITS-1:0]  w_h_cnt_nxt;
    logic [V_CNT_BITS-1:0]  w_v_cnt_nxt;
    logic                   w_de_nxt;
    logic [WIDTH_BITS-1:0]  w_x_nxt;
    logic [HEIGHT_BITS-1:0] w_y_nxt;
    logic                   w_fs_nxt;

    always_comb begin
        // The dot boundary is the edge on which phase wraps to 0.
        w_dot_end   = (r_phase == PHASE_LAST);
        w_phase_nxt = w_dot_end ? '0 : r_phase + 1'b1;

        case (r_h_state)
            H_SYNC_S:   w_h_last = (r_h_cnt == H_SYNC_LAST);
            H_BACK_S:   w_h_last = (r_h_cnt == H_BACK_LAST);
            H_ACTIVE_S: w_h_last = (r_h_cnt == H_ACTIVE_LAST);
            H_FRONT_S:  w_h_last = (r_h_cnt == H_FRONT_LAST);
            default:    w_h_last = 1'b1;
        endcase

        case (r_v_state)
            V_SYNC_S:   w_v_last = (r_v_cnt == V_SYNC_LAST);
            V_BACK_S:   w_v_last = (r_v_cnt == V_BACK_LAST);
            V_ACTIVE_S: w_v_last = (r_v_cnt == V_ACTIVE_LAST);
            V_FRONT_S:  w_v_last = (r_v_cnt == V_FRONT_LAST);
            default:    w_v_last = 1'b1;
        endcase

        w_h_state_nxt = r_h_state;
        w_h_cnt_nxt   = r_h_cnt;
        w_v_state_nxt = r_v_state;
        w_v_cnt_nxt   = r_v_cnt;

        if (w_dot_end) begin
            if (w_h_last) begin
                w_h_cnt_nxt = '0;
                case (r_h_state)
                    H_SYNC_S:   w_h_state_nxt = H_BACK_S;
                    H_BACK_S:   w_h_state_nxt = H_ACTIVE_S;
                    H_ACTIVE_S: w_h_state_nxt = H_FRONT_S;
                    H_FRONT_S:  w_h_state_nxt = H_SYNC_S;
                    default:    w_h_state_nxt = H_SYNC_S;
                endcase

                // A line ends on the boundary that leaves the front porch;
                // only then does the vertical machine move.
                if (r_h_state == H_FRONT_S) begin
                    if (w_v_last) begin
                        w_v_cnt_nxt = '0;
                        case (r_v_state)
                            V_SYNC_S:   w_v_state_nxt = V_BACK_S;
                            V_BACK_S:   w_v_state_nxt = V_ACTIVE_S;
                            V_ACTIVE_S: w_v_state_nxt = V_FRONT_S;
                            V_FRONT_S:  w_v_state_nxt = V_SYNC_S;
                            default:    w_v_state_nxt = V_SYNC_S;
                        endcase
                    end else begin
                        w_v_cnt_nxt = r_v_cnt + 1'b1;
                    end
                end
            end else begin
                w_h_cnt_nxt = r_h_cnt + 1'b1;
            end
        end

        // Output decode from next-state values so registered outputs carry no lag.
        w_de_nxt = (w_h_state_nxt == H_ACTIVE_S) && (w_v_state_nxt == V_ACTIVE_S);
        w_x_nxt  = w_de_nxt ? w_h_cnt_nxt[WIDTH_BITS-1:0]  : '0;
        w_y_nxt  = w_de_nxt ? w_v_cnt_nxt[HEIGHT_BITS-1:0] : '0;

        // The pulse is taken from the first clock of dot (0,0) (the reset state
        // included), so it appears on the clock right after reset release and
        // once per frame after that, still inside dot (0,0).
        w_fs_nxt = (r_phase == '0) && (r_h_state == H_SYNC_S) && (r_v_state == V_SYNC_S)
                   && (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= '0;
            r_h_state     <= H_SYNC_S;
            r_v_state     <= V_SYNC_S;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_display_x   <= '0;
            r_display_y   <= '0;
            r_de          <= 1'b0;
            r_hsync_n     <= 1'b0;
            r_vsync_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_h_state     <= w_h_state_nxt;
            r_v_state     <= w_v_state_nxt;
            r_h_cnt       <= w_h_cnt_nxt;
            r_v_cnt       <= w_v_cnt_nxt;
            r_display_x   <= w_x_nxt;
            r_display_y   <= w_y_nxt;
            r_de          <= w_de_nxt;
            r_hsync_n     <= (w_h_state_nxt != H_SYNC_S);
            r_vsync_n     <= (w_v_state_nxt != V_SYNC_S);
            r_frame_start <= w_fs_nxt;
        end
    end

`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Advances on the same edge that raises frame_start, so the value already
    // reads 1 while the first frame's pulse is high; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_fs_nxt) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign display_x         = r_display_x;
    assign display_y         = r_display_y;
    assign in_display_region = r_de;
    assign de                = r_de;
    assign hsync_n           = r_hsync_n;
    assign vsync_n           = r_vsync_n;
    assign frame_start       = r_frame_start;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default-sized instance for the panel timing
// numbers, and a small-raster instance so several whole frames fit in a short run.
// Both are compared every clock with a model that works from the clock count
// since reset release using plain division/modulo over the raster geometry.
module tb_display_timing_gen;

    logic clk;
    logic rst;
    int   t;          // clocks since reset release (0 during reset)
    int   n_checks;
    int   n_errors;
    int   seg;        // -1 before first release, 0 first run, 1 afterwards

    // default-parameter instance
    logic [7:0] d_x;
    logic [8:0] d_y;
    logic       d_reg, d_de, d_hs, d_vs, d_fs;
    // small instance: W=6 H=4, H 2/3/2, V 1/2/1, 2 clocks per dot
    logic [2:0] s_x;
    logic [1:0] s_y;
    logic       s_reg, s_de, s_hs, s_vs, s_fs;
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    display_timing_gen u_dut (
        .clk(clk), .reset(rst),
        .display_x(d_x), .display_y(d_y), .in_display_region(d_reg), .de(d_de),
        .hsync_n(d_hs), .vsync_n(d_vs), .frame_start(d_fs)
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        , .frame_count(d_fc)
`endif
    );

    display_timing_gen #(
        .DISPLAY_WIDTH(6), .DISPLAY_HEIGHT(4),
        .H_SYNC(2), .H_BACK(3), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_FRONT(1),
        .CLKS_PER_PIXEL(2)
    ) u_small (
        .clk(clk), .reset(rst),
        .display_x(s_x), .display_y(s_y), .in_display_region(s_reg), .de(s_de),
        .hsync_n(s_hs), .vsync_n(s_vs), .frame_start(s_fs)
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Expected outputs at clock tt after release, from the raster geometry alone.
    task automatic model(input int tt, input int cpp, input int w, input int h,
                         input int hs, input int hb, input int hf,
                         input int vs, input int vb, input int vf,
                         output int hsn, output int vsn, output int de,
                         output int x, output int y, output int fs, output int fc);
        int ht, vt, fclk, dot, hd, ln, deh, dev;
        ht   = hs + hb + w + hf;
        vt   = vs + vb + h + vf;
        fclk = ht * vt * cpp;
        dot  = tt / cpp;
        hd   = dot % ht;
        ln   = (dot / ht) % vt;
        hsn  = (hd < hs) ? 0 : 1;
        vsn  = (ln < vs) ? 0 : 1;
        deh  = (hd >= hs + hb) && (hd < hs + hb + w);
        dev  = (ln >= vs + vb) && (ln < vs + vb + h);
        de   = deh && dev;
        x    = de ? hd - hs - hb : 0;
        y    = de ? ln - vs - vb : 0;
        fs   = ((tt % fclk) == 1) ? 1 : 0;
        fc   = (tt == 0) ? 0 : (((tt - 1) / fclk + 1) % 65536);
    endtask

    // Per-clock compare process plus pinned literal expectations.
    initial begin
        int hsn, vsn, de, x, y, fs, fc;
        int prev_hs, last_fall, de_cnt, hs_cnt, svs_cnt;
        prev_hs = 0; last_fall = -1; de_cnt = 0; hs_cnt = 0; svs_cnt = 0;
        forever begin
            @(negedge clk);
            model(t, 4, 240, 320, 10, 20, 10, 2, 2, 4, hsn, vsn, de, x, y, fs, fc);
            chk("dflt_hsync_n", d_hs, hsn);
            chk("dflt_vsync_n", d_vs, vsn);
            chk("dflt_de", d_de, de);
            chk("dflt_in_region", d_reg, de);
            chk("dflt_x", d_x, x);
            chk("dflt_y", d_y, y);
            chk("dflt_frame_start", d_fs, fs);
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
            chk("dflt_frame_count", d_fc, fc);
`endif
            model(t, 2, 6, 4, 2, 3, 2, 1, 2, 1, hsn, vsn, de, x, y, fs, fc);
            chk("small_hsync_n", s_hs, hsn);
            chk("small_vsync_n", s_vs, vsn);
            chk("small_de", s_de, de);
            chk("small_in_region", s_reg, de);
            chk("small_x", s_x, x);
            chk("small_y", s_y, y);
            chk("small_frame_start", s_fs, fs);
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
            chk("small_frame_count", s_fc, fc);
`endif

            if (seg == 0) begin
                // hand-computed default-raster numbers
                if (t == 1)    chk("lit_fs_clk1", d_fs, 1);
                if (t == 2)    chk("lit_fs_clk2", d_fs, 0);
                if (t == 4599) chk("lit_de_4599", d_de, 0);
                if (t == 4600) begin
                    chk("lit_de_4600", d_de, 1);
                    chk("lit_x_4600", d_x, 0);
                    chk("lit_y_4600", d_y, 0);
                end
                if (t == 4603) chk("lit_x_4603", d_x, 0);
                if (t == 4604) chk("lit_x_4604", d_x, 1);
                if (t == 5559) chk("lit_x_5559", d_x, 239);
                if (t == 5560) chk("lit_de_5560", d_de, 0);
                if (t == 2239) chk("lit_vs_2239", d_vs, 0);
                if (t == 2240) chk("lit_vs_2240", d_vs, 1);
                if (t >= 1120 && t < 2240 && d_hs == 1'b0) hs_cnt++;
                if (t == 2240) chk("lit_hsync_low_clks", hs_cnt, 40);
                if (t >= 4480 && t < 5600 && d_de == 1'b1) de_cnt++;
                if (t == 5600) chk("lit_de_clks_line", de_cnt, 960);
                if (prev_hs == 1 && d_hs == 1'b0) begin
                    if (last_fall >= 0) chk("lit_hsync_period", t - last_fall, 1120);
                    last_fall = t;
                end
                // hand-computed small-raster numbers (frame = 208 clocks)
                if (t == 176) begin
                    chk("lit_small_last_x", s_x, 5);
                    chk("lit_small_last_y", s_y, 3);
                    chk("lit_small_last_de", s_de, 1);
                end
                if (t == 178) chk("lit_small_de_178", s_de, 0);
                if (t == 209) chk("lit_small_fs_209", s_fs, 1);
                if (t >= 208 && t < 416 && s_vs == 1'b0) svs_cnt++;
                if (t == 416) chk("lit_small_vsync_clks", svs_cnt, 26);
            end
            prev_hs = d_hs;
        end
    end

    // Reset values must appear without waiting for a clock.
    task automatic check_async_reset();
        chk("arst_dflt_hsync_n", d_hs, 0);
        chk("arst_dflt_vsync_n", d_vs, 0);
        chk("arst_dflt_de", d_de, 0);
        chk("arst_dflt_region", d_reg, 0);
        chk("arst_dflt_x", d_x, 0);
        chk("arst_dflt_y", d_y, 0);
        chk("arst_dflt_fs", d_fs, 0);
        chk("arst_small_de", s_de, 0);
        chk("arst_small_x", s_x, 0);
        chk("arst_small_y", s_y, 0);
        chk("arst_small_hsync_n", s_hs, 0);
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        chk("arst_dflt_fc", d_fc, 0);
`endif
    endtask

    task automatic mid_reset(input int dly, input int hold);
        @(posedge clk);
        #(dly);
        rst = 1'b1;
        #1;
        check_async_reset();
        repeat (hold) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        seg = -1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        seg = 0;
        repeat (6000) @(negedge clk);
        seg = 1;
        // default raster is inside an active line here (t ~ 6000)
        chk("pre_reset_dflt_de", d_de, 1);
        mid_reset(2, 3);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(50, 4000)) @(negedge clk);
            mid_reset($urandom_range(1, 3), $urandom_range(1, 4));
        end
        repeat (5000) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
